// File: rtl/lsu_mem_ctrl_if.sv
// Request/response and word-memory bus of the load/store controller.
// slave = controller side, master = execute stage + memory side.
interface lsu_mem_ctrl_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [1:0]      req_size;
    logic            req_signed;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;

    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_rdata;
    logic            resp_err;

    logic            mem_EN;
    logic            mem_RW;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [XLEN-1:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        input  resp_ready, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_EN, mem_RW, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        output resp_ready, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_EN, mem_RW, mem_addr, mem_wdata
    );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller for a word-wide synchronous memory; sub-word stores use read-modify-write.
// Optional LSU_MISALIGN_CHECK_EN: misaligned half/word accesses answer at once with resp_err=1.
module lsu_mem_ctrl #(
    parameter int XLEN    = 32,
    parameter int AW_WORD = 2
) (
    input logic           clk,
    input logic           rst_n,
    lsu_mem_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ACCESS, RD_WAIT, MERGE, RESP} state_t;

    state_t          state;
    logic            we_q;
    logic [1:0]      size_q;
    logic            sgn_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic            resp_valid_q;
    logic [XLEN-1:0] resp_rdata_q;
    logic            resp_err_q;

    logic            misaligned;
    logic [7:0]      lane_b;
    logic [15:0]     lane_h;
    logic [XLEN-1:0] load_val;
    logic [XLEN-1:0] merge_val;

`ifdef LSU_MISALIGN_CHECK_EN
    assign misaligned = (bus.req_size == 2'b01 && bus.req_addr[0]) ||
                        (bus.req_size[1] && bus.req_addr[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    // Little-endian lane pick; half lanes use addr[1] only.
    always_comb begin
        lane_b   = bus.mem_rdata[{addr_q[1:0], 3'b000} +: 8];
        lane_h   = bus.mem_rdata[{addr_q[1], 4'b0000} +: 16];
        load_val = bus.mem_rdata;
        case (size_q)
            2'b00:   load_val = {{(XLEN-8){lane_b[7] & sgn_q}}, lane_b};
            2'b01:   load_val = {{(XLEN-16){lane_h[15] & sgn_q}}, lane_h};
            default: load_val = bus.mem_rdata;
        endcase
    end

    always_comb begin
        merge_val = bus.mem_rdata;
        case (size_q)
            2'b00:   merge_val[{addr_q[1:0], 3'b000} +: 8]  = wdata_q[7:0];
            2'b01:   merge_val[{addr_q[1], 4'b0000} +: 16]  = wdata_q[15:0];
            default: merge_val = wdata_q;
        endcase
    end

    // Memory side is decoded from state so a reset drops an in-flight cycle immediately.
    always_comb begin
        bus.mem_EN    = (state == ACCESS) || (state == MERGE);
        bus.mem_RW    = (state == MERGE) || (state == ACCESS && we_q && size_q[1]);
        bus.mem_addr  = bus.mem_EN ? (addr_q >> AW_WORD) : '0;
        bus.mem_wdata = '0;
        if (state == MERGE)
            bus.mem_wdata = merge_val;
        else if (state == ACCESS && bus.mem_RW)
            bus.mem_wdata = wdata_q;
    end

    assign bus.req_ready  = (state == IDLE);
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            we_q         <= 1'b0;
            size_q       <= 2'b00;
            sgn_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        we_q    <= bus.req_we;
                        size_q  <= bus.req_size;
                        sgn_q   <= bus.req_signed;
                        addr_q  <= bus.req_addr;
                        wdata_q <= bus.req_wdata;
                        if (misaligned) begin
                            resp_valid_q <= 1'b1;
                            resp_rdata_q <= '0;
                            resp_err_q   <= 1'b1;
                            state        <= RESP;
                        end else begin
                            state <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    if (!we_q) begin
                        state <= RD_WAIT;
                    end else if (size_q[1]) begin
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= '0;
                        resp_err_q   <= 1'b0;
                        state        <= RESP;
                    end else begin
                        state <= MERGE;
                    end
                end
                RD_WAIT: begin
                    resp_valid_q <= 1'b1;
                    resp_rdata_q <= load_val;
                    resp_err_q   <= 1'b0;
                    state        <= RESP;
                end
                MERGE: begin
                    resp_valid_q <= 1'b1;
                    resp_rdata_q <= '0;
                    resp_err_q   <= 1'b0;
                    state        <= RESP;
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        resp_valid_q <= 1'b0;
                        resp_rdata_q <= '0;
                        resp_err_q   <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
